// File: rtl/sseg_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller.
package sseg_ctrl_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLoad,
        StSend,
        StWait,
        StNext
    } state_e;

    // Display register addresses.
    localparam logic [7:0] RegDecode    = 8'h09;
    localparam logic [7:0] RegIntensity = 8'h0A;
    localparam logic [7:0] RegScanLimit = 8'h0B;
    localparam logic [7:0] RegShutdown  = 8'h0C;
    localparam logic [7:0] RegDispTest  = 8'h0F;
    localparam logic [7:0] RegDigitBase = 8'h01;

    // Number of packets in the configuration sequence.
    localparam int unsigned InitLen = 5;

    // Select digit nibble i (0 = digit 1) from the packed digit word.
    function automatic logic [3:0] digit_nibble(input logic [31:0] d, input logic [2:0] i);
        return d[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sseg_cfg_rom.sv
// Configuration table: INIT index -> {register address, data byte}.
module sseg_cfg_rom
    import sseg_ctrl_pkg::*;
#(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'h7
) (
    input  logic [2:0] idx,
    output logic [7:0] addr,
    output logic [7:0] dat
);

    // Pure lookup; indices past the table map to zero.
    always_comb begin
        addr = 8'h00;
        dat  = 8'h00;
        case (idx)
            3'd0: begin addr = RegShutdown;  dat = 8'h01;               end
            3'd1: begin addr = RegDecode;    dat = 8'hFF;               end
            3'd2: begin addr = RegIntensity; dat = {4'h0, INTENSITY};   end
            3'd3: begin addr = RegScanLimit; dat = {5'h00, SCAN_LIMIT}; end
            3'd4: begin addr = RegDispTest;  dat = 8'h00;               end
            default: begin addr = 8'h00; dat = 8'h00; end
        endcase
    end

endmodule

// File: rtl/sseg_ctrl.sv
// Seven-segment display controller: sends the configuration sequence after reset,
// then digit frames on request, on a pending request, or on periodic refresh.
module sseg_ctrl
    import sseg_ctrl_pkg::*;
#(
    parameter logic [3:0]  INTENSITY   = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT  = 3'h7,
    parameter int unsigned REFRESH_CYC = 100000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic        upd,
    input  logic        pkt_done,
    output logic        pkt_req,
    output logic [7:0]  pkt_addr,
    output logic [7:0]  pkt_dat,
    output logic        busy,
    output logic        init_done
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        init_q, init_d;
    logic        pend_q, pend_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] ref_q, ref_d;
    logic [31:0] dig_q, dig_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dat_q, dat_d;
    logic        load_pkt;
    logic [7:0]  rom_addr, rom_dat;

    // The ROM is addressed with the next index so the packet registers load on entry to SEND.
    sseg_cfg_rom #(
        .INTENSITY (INTENSITY),
        .SCAN_LIMIT(SCAN_LIMIT)
    ) u_cfg_rom (
        .idx (idx_d),
        .addr(rom_addr),
        .dat (rom_dat)
    );

    // Next-state, counters and packet latch control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        init_d   = init_q;
        pend_d   = pend_q;
        tmo_d    = '0;
        ref_d    = '0;
        dig_d    = dig_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        load_pkt = 1'b0;

        if (upd && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StInit: begin
                state_d  = StSend;
                load_pkt = 1'b1;
            end
            StIdle: begin
                if (upd || pend_q || (ref_q == 32'(REFRESH_CYC - 1))) begin
                    state_d = StLoad;
                end else begin
                    ref_d = ref_q + 32'd1;
                end
            end
            StLoad: begin
                dig_d    = digits;
                idx_d    = '0;
                state_d  = StSend;
                load_pkt = 1'b1;
            end
            StSend: begin
                state_d = StWait;
            end
            StWait: begin
                if (pkt_done) begin
                    state_d = StNext;
                end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
                    // Retry: packet registers are untouched, so the same packet goes out.
                    state_d = StSend;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StNext: begin
                idx_d = idx_q + 3'd1;
                if (!init_q && (idx_q == 3'(InitLen - 1))) begin
                    state_d = StLoad;
                    init_d  = 1'b1;
                    idx_d   = '0;
                end else if (init_q && (idx_q == 3'd7)) begin
                    state_d = StIdle;
                end else begin
                    state_d  = StSend;
                    load_pkt = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // A frame about to start absorbs any outstanding request.
        if ((state_d == StLoad) && (state_q != StLoad)) begin
            pend_d = 1'b0;
        end

        if (load_pkt) begin
            if (init_d) begin
                addr_d = RegDigitBase + {5'h00, idx_d};
                dat_d  = {4'h0, digit_nibble(dig_d, idx_d)};
            end else begin
                addr_d = rom_addr;
                dat_d  = rom_dat;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            idx_q   <= '0;
            init_q  <= 1'b0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
            ref_q   <= '0;
            dig_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            init_q  <= init_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            ref_q   <= ref_d;
            dig_q   <= dig_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    // Outputs are forced to their reset values for the whole time rst is high.
    always_comb begin
        pkt_req   = (state_q == StSend) && !rst;
        pkt_addr  = rst ? 8'h00 : addr_q;
        pkt_dat   = rst ? 8'h00 : dat_q;
        busy      = rst || (state_q != StIdle);
        init_done = init_q && !rst;
    end

endmodule

// File: tb/tb_sseg_ctrl.sv
// Directed bench for sseg_ctrl with a bench-driven packet sender model.
module tb_sseg_ctrl;

    localparam int DoneDly = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic        upd;
    logic        pkt_done;
    logic        pkt_req;
    logic [7:0]  pkt_addr;
    logic [7:0]  pkt_dat;
    logic        busy;
    logic        init_done;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    sseg_ctrl #(
        .INTENSITY  (4'h8),
        .SCAN_LIMIT (3'h7),
        .REFRESH_CYC(50),
        .TIMEOUT_CYC(1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digits   (digits),
        .upd      (upd),
        .pkt_done (pkt_done),
        .pkt_req  (pkt_req),
        .pkt_addr (pkt_addr),
        .pkt_dat  (pkt_dat),
        .busy     (busy),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next cycle with pkt_req high; returns its cycle number.
    task automatic wait_req(input string tag, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 4000) begin
            tick();
            n++;
            if (pkt_req) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no pkt_req within %0d cycles", tag, n);
        end
    endtask

    // One packet: expect addr/dat, optionally withhold done once, optionally pulse upd.
    task automatic pkt(input string tag, input logic [7:0] a, input logic [7:0] d,
                       input bit pulse_upd, input bit withhold);
        int t0, t1;
        wait_req(tag, t0);
        check({tag, " addr"}, 32'(pkt_addr), 32'(a));
        check({tag, " dat"}, 32'(pkt_dat), 32'(d));
        if (withhold) begin
            // SEND cycle plus 1024 WAIT cycles before the reissue.
            wait_req({tag, " retry"}, t1);
            check({tag, " retry gap"}, 32'(t1 - t0), 32'd1025);
            check({tag, " retry addr"}, 32'(pkt_addr), 32'(a));
            check({tag, " retry dat"}, 32'(pkt_dat), 32'(d));
        end
        if (pulse_upd) begin
            upd = 1'b1;
            tick();
            upd = 1'b0;
            repeat (DoneDly - 1) tick();
        end else begin
            repeat (DoneDly) tick();
        end
        check({tag, " hold addr"}, 32'(pkt_addr), 32'(a));
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [31:0] dg, input int from, input int upto,
                         input logic [7:0] upd_mask, input logic [7:0] hold_mask);
        for (int i = from; i <= upto; i++) begin
            pkt($sformatf("%s p%0d", tag, i + 1), 8'(i + 1), {4'h0, dg[i*4 +: 4]},
                upd_mask[i], hold_mask[i]);
        end
    endtask

    task automatic cfg_seq(input string tag);
        pkt({tag, " 0C"}, 8'h0C, 8'h01, 1'b0, 1'b0);
        check({tag, " init_done low"}, 32'(init_done), 32'd0);
        pkt({tag, " 09"}, 8'h09, 8'hFF, 1'b0, 1'b0);
        pkt({tag, " 0A"}, 8'h0A, 8'h08, 1'b0, 1'b0);
        pkt({tag, " 0B"}, 8'h0B, 8'h07, 1'b0, 1'b0);
        pkt({tag, " 0F"}, 8'h0F, 8'h00, 1'b0, 1'b0);
        tick();
        check({tag, " init_done"}, 32'(init_done), 32'd1);
    endtask

    // From the NEXT cycle after a frame's last packet, count IDLE cycles until busy again.
    task automatic idle_run(output int n);
        n = 0;
        tick();
        while (!busy && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pkt_req"}, 32'(pkt_req), 32'd0);
        check({tag, " pkt_addr"}, 32'(pkt_addr), 32'd0);
        check({tag, " pkt_dat"}, 32'(pkt_dat), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " init_done"}, 32'(init_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        rst      = 1'b1;
        upd      = 1'b0;
        pkt_done = 1'b0;
        digits   = 32'h1234_5678;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Config sequence, then a frame that must ignore a mid-frame digits change.
        cfg_seq("cfg");
        pkt("f0 p1", 8'h01, 8'h08, 1'b0, 1'b0);
        digits = 32'h1111_2222;
        frame("f0", 32'h1234_5678, 1, 7, 8'h00, 8'h00);
        idle_run(n);
        check("refresh gap 1", 32'(n), 32'd50);

        // Refresh frame picks up the new digits.
        frame("refresh", 32'h1111_2222, 0, 7, 8'h00, 8'h00);
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // upd in IDLE; three upd pulses during this frame coalesce into one more frame.
        digits = 32'h8765_4321;
        upd    = 1'b1;
        tick();
        upd    = 1'b0;
        frame("upd", 32'h8765_4321, 0, 7, 8'b0010_1010, 8'h00);
        idle_run(n);
        check("pending gap", 32'(n), 32'd1);
        frame("pending", 32'h8765_4321, 0, 7, 8'h00, 8'h00);
        idle_run(n);
        check("no extra frame", 32'(n), 32'd50);

        // Refresh frame with done withheld on addr 03.
        frame("timeout", 32'h8765_4321, 0, 7, 8'h00, 8'b0000_0100);

        // upd lands in the same cycle as refresh expiry: one frame only.
        n = 0;
        tick();
        while (n < 49) begin
            n++;
            tick();
        end
        check("pre-merge idle", 32'(busy), 32'd0);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        check("merge load", 32'(busy), 32'd1);
        frame("merge", 32'h8765_4321, 0, 7, 8'h00, 8'h00);
        idle_run(n);
        check("merge single", 32'(n), 32'd50);

        // Reset during the addr 05 packet aborts and restarts configuration.
        frame("abort", 32'h8765_4321, 0, 3, 8'h00, 8'h00);
        wait_req("abort p5", t);
        check("abort p5 addr", 32'(pkt_addr), 32'h05);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid reset");
        tick();
        rst = 1'b0;
        cfg_seq("recfg");
        frame("post", 32'h8765_4321, 0, 7, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
